// File: rtl/uart_pkg.sv
// uart_pkg: shared state/parity encodings and frame-config helpers for the UART family
package uart_pkg;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  localparam logic [1:0] PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2;
  function automatic int unsigned div_default(input int unsigned clk_freq, input int unsigned bps);
    return clk_freq / bps;
  endfunction
  function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int max_w);
    return (bits < 4'd5) ? 4'd5 : (int'(bits) > max_w) ? 4'(max_w) : bits;
  endfunction
  function automatic int unsigned clamp_div(input int unsigned div, input int unsigned dflt);
    return (div == 0) ? dflt : (div == 1) ? 2 : div;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, ticks on the last cycle of each period
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = enable && (cnt == divisor - DIV_W'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (enable && !tick) ? cnt + DIV_W'(1) : '0;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: run-time configurable UART transmitter with valid/ready input
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200,
  parameter int          DATA_W   = 8,
  parameter int          DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic [DIV_W-1:0]  cfg_baud_div,
  output logic              uart_txd,
  output logic              uart_tx_busy,
  output logic              uart_tx_done
);
  localparam int unsigned DIV_DEFAULT = div_default(CLK_FREQ, UART_BPS);
  logic [2:0] state, state_n;
  logic [3:0] idx, idx_n, nbits_q, nbits_in;
  logic [DATA_W-1:0] data_q, mask, sh;
  logic [DIV_W-1:0] div_q;
  logic par_en_q, par_bit_q, stop2_q, tick, txd_n, last_data, last_stop;
  assign nbits_in = clamp_bits(cfg_data_bits, DATA_W);
  always_comb for (int i = 0; i < DATA_W; i++) mask[i] = i < int'(nbits_in);
  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk(clk), .rst_n(rst_n), .enable(state != IDLE), .divisor(div_q), .tick(tick)
  );
  assign last_data = idx == nbits_q - 4'd1;
  assign last_stop = idx == {3'd0, stop2_q};
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: if (tx_valid) begin state_n = START; idx_n = '0; end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        state_n = last_data ? (par_en_q ? PARITY : STOP) : DATA;
        idx_n = last_data ? 4'd0 : idx + 4'd1;
      end
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) begin
        state_n = last_stop ? IDLE : STOP;
        idx_n = last_stop ? 4'd0 : idx + 4'd1;
      end
      default: begin state_n = IDLE; idx_n = '0; end
    endcase
    sh = data_q >> idx_n;
    // txd is registered from next-state so the pad never sees decode glitches
    txd_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh[0] : (state_n == PARITY) ? par_bit_q : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      data_q <= '0;
      nbits_q <= '0;
      div_q <= '0;
      par_en_q <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q <= 1'b0;
      uart_txd <= 1'b1;
      uart_tx_busy <= 1'b0;
      uart_tx_done <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      state <= state_n;
      idx <= idx_n;
      uart_txd <= txd_n;
      uart_tx_busy <= state_n != IDLE;
      tx_ready <= state_n == IDLE;
      uart_tx_done <= (state == STOP) && (state_n == IDLE);
      if (tx_valid && tx_ready) begin
        data_q <= tx_data;
        nbits_q <= nbits_in;
        par_en_q <= (cfg_parity == PAR_ODD) || (cfg_parity == PAR_EVEN);
        par_bit_q <= (^(tx_data & mask)) ^ (cfg_parity == PAR_ODD);
        stop2_q <= cfg_stop2;
        div_q <= DIV_W'(clamp_div(32'(cfg_baud_div), DIV_DEFAULT));
      end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed frame checks for uart_tx_cfg
module tb_uart_tx_cfg;
  logic clk = 0, rst_n = 1, tx_valid = 0, cfg_stop2 = 0;
  logic tx_ready, uart_txd, uart_tx_busy, uart_tx_done;
  logic [7:0] tx_data = '0;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = '0;
  logic [15:0] cfg_baud_div = '0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_tx_cfg dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .cfg_baud_div(cfg_baud_div), .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy),
    .uart_tx_done(uart_tx_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                      input logic s2, input logic [15:0] div, input logic hold);
    tx_data = d;
    cfg_data_bits = nb;
    cfg_parity = par;
    cfg_stop2 = s2;
    cfg_baud_div = div;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = hold;
  endtask
  // eb holds the expected line level per bit period, start bit at index 0
  task automatic capture(input string tag, input logic [15:0] eb, input int len, input int d);
    int n = 0, dn = 0, bad_bits = 0;
    chk({tag, " ready_low"}, tx_ready, 0);
    while (uart_tx_busy && n < len * d + 64) begin
      if (uart_txd !== ((n / d < len) ? eb[n / d] : 1'b1)) bad_bits++;
      dn += int'(uart_tx_done);
      n++;
      @(negedge clk);
    end
    chk({tag, " cycles"}, n, len * d);
    chk({tag, " bits"}, bad_bits, 0);
    chk({tag, " done_in_frame"}, dn, 0);
    chk({tag, " done_end"}, uart_tx_done, 1);
    chk({tag, " ready_end"}, tx_ready, 1);
    chk({tag, " txd_end"}, uart_txd, 1);
  endtask
  initial begin
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst txd", uart_txd, 1);
    chk("rst busy", uart_tx_busy, 0);
    chk("rst done", uart_tx_done, 0);
    chk("rst ready", tx_ready, 1);
    rst_n = 1;
    @(negedge clk);
    send(8'h55, 4'd8, 2'd0, 1'b0, 16'd0, 1'b0);
    capture("div0_8n1", 16'b1010101010, 10, 434);
    @(negedge clk);
    chk("div0 done_once", uart_tx_done, 0);
    send(8'h07, 4'd8, 2'd2, 1'b0, 16'd4, 1'b0);
    capture("d4_even", 16'b11000001110, 11, 4);
    send(8'hFF, 4'd5, 2'd0, 1'b1, 16'd4, 1'b0);
    capture("d4_5n2", 16'b11111110, 8, 4);
    send(8'hA5, 4'd8, 2'd0, 1'b0, 16'd2, 1'b1);
    capture("b2b_a5", 16'b1101001010, 10, 2);
    tx_data = 8'h3C;
    @(negedge clk);
    tx_valid = 0;
    capture("b2b_3c", 16'b1001111000, 10, 2);
    send(8'h07, 4'd8, 2'd2, 1'b0, 16'd4, 1'b0);
    cfg_parity = 2'd1;
    cfg_baud_div = 16'd6;
    capture("cfg_hold", 16'b11000001110, 11, 4);
    send(8'h07, 4'd8, 2'd1, 1'b0, 16'd6, 1'b0);
    capture("cfg_next_odd", 16'b10000001110, 11, 6);
    send(8'h55, 4'd8, 2'd0, 1'b0, 16'd4, 1'b0);
    repeat (17) @(negedge clk);
    chk("pre_rst txd", uart_txd, 0);
    chk("pre_rst busy", uart_tx_busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst txd", uart_txd, 1);
    chk("mid_rst busy", uart_tx_busy, 0);
    chk("mid_rst done", uart_tx_done, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst ready", tx_ready, 1);
    chk("post_rst txd", uart_txd, 1);
    send(8'h3C, 4'd8, 2'd0, 1'b0, 16'd4, 1'b0);
    capture("post_rst", 16'b1001111000, 10, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
